// File: rtl/mult_error_accum.sv
// mult_error_accum: error statistics (count, ED sum, max ED) for approximate multiplier outputs.
// Define MULT_ERR_SQ_EN to also accumulate the saturating sum of squared ED on sum_sq_ed.
module mult_error_accum #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2*WIDTH:0] approx_prod,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] sum_ed,
    output logic [2*WIDTH:0] max_ed,
    output logic [ACC_W-1:0] sum_sq_ed
);
    localparam int EDW = 2*WIDTH+1;
    localparam int SW  = ((ACC_W > EDW) ? ACC_W : EDW) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0] num_q, accepted;
    logic [2:1]       vld_pipe;
    logic             xfer, clr;
    logic [WIDTH-1:0] s1_a, s1_b;
    logic [EDW-1:0]   s1_p, exact_c, ed_c, ed_q;
    logic [SW-1:0]    sum_ext;

    assign xfer = in_valid & in_ready;
    assign clr  = (state == IDLE) & start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (num_samples != '0) ? RUN : DONE;
            RUN:     if (xfer && accepted == num_q - CNT_W'(1)) state_nxt = DRAIN;
            DRAIN:   if (vld_pipe == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == RUN) && (accepted < num_q);
        busy     = (state == RUN) || (state == DRAIN);
        done     = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q    <= '0;
            accepted <= '0;
        end else if (clr) begin
            num_q    <= num_samples;
            accepted <= '0;
        end else if (xfer) begin
            accepted <= accepted + CNT_W'(1);
        end
    end

    // Fixed three-stage pipe: S1 capture, S2 exact product / ED, S3 statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[1], xfer};
    end

    assign exact_c = EDW'(s1_a) * EDW'(s1_b);
    assign ed_c    = (s1_p >= exact_c) ? s1_p - exact_c : exact_c - s1_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_a <= '0;
            s1_b <= '0;
            s1_p <= '0;
            ed_q <= '0;
        end else begin
            if (xfer) begin
                s1_a <= op_a;
                s1_b <= op_b;
                s1_p <= approx_prod;
            end
            if (vld_pipe[1]) ed_q <= ed_c;
        end
    end

    // Widened add so the carry out of ACC_W bits is visible for saturation.
    assign sum_ext = SW'(sum_ed) + SW'(ed_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_count <= '0;
            err_count    <= '0;
            sum_ed       <= '0;
            max_ed       <= '0;
        end else if (clr) begin
            sample_count <= '0;
            err_count    <= '0;
            sum_ed       <= '0;
            max_ed       <= '0;
        end else if (vld_pipe[2]) begin
            sample_count <= sample_count + CNT_W'(1);
            if (ed_q != '0) err_count <= err_count + CNT_W'(1);
            sum_ed <= (|sum_ext[SW-1:ACC_W]) ? '1 : sum_ext[ACC_W-1:0];
            if (ed_q > max_ed) max_ed <= ed_q;
        end
    end

`ifdef MULT_ERR_SQ_EN
    localparam int SQW = 2*EDW;
    localparam int QW  = ((ACC_W > SQW) ? ACC_W : SQW) + 1;

    logic [SQW-1:0]   sq_q;
    logic [QW-1:0]    sq_ext;
    logic [ACC_W-1:0] sum_sq_q;

    assign sq_ext = QW'(sum_sq_q) + QW'(sq_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              sq_q <= '0;
        else if (vld_pipe[1]) sq_q <= SQW'(ed_c) * SQW'(ed_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              sum_sq_q <= '0;
        else if (clr)         sum_sq_q <= '0;
        else if (vld_pipe[2]) sum_sq_q <= (|sq_ext[QW-1:ACC_W]) ? '1 : sq_ext[ACC_W-1:0];
    end

    assign sum_sq_ed = sum_sq_q;
`else
    assign sum_sq_ed = '0;
`endif

endmodule

// File: tb/tb_mult_error_accum.sv
// Randomized bench for mult_error_accum: a wide-accumulator instance and an 8-bit
// accumulator instance share stimulus and are checked against a plain-arithmetic model.
module tb_mult_error_accum;
    localparam int W = 8, CW = 32, AW = 48, AWS = 8;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
    logic [CW-1:0]  num_samples = '0;
    logic [W-1:0]   op_a = '0, op_b = '0;
    logic [2*W:0]   approx_prod = '0;
    logic           in_ready, busy, done, s_in_ready, s_busy, s_done;
    logic [CW-1:0]  sample_count, err_count, s_sample_count, s_err_count;
    logic [AW-1:0]  sum_ed, sum_sq_ed;
    logic [AWS-1:0] s_sum_ed, s_sum_sq_ed;
    logic [2*W:0]   max_ed, s_max_ed;

    int n_vec = 0, n_err = 0;
    int qa[$], qb[$], qp[$];

    always #5 clk = ~clk;

    mult_error_accum #(.WIDTH(W), .CNT_W(CW), .ACC_W(AW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b),
        .approx_prod(approx_prod), .busy(busy), .done(done),
        .sample_count(sample_count), .err_count(err_count), .sum_ed(sum_ed),
        .max_ed(max_ed), .sum_sq_ed(sum_sq_ed)
    );

    mult_error_accum #(.WIDTH(W), .CNT_W(CW), .ACC_W(AWS)) u_sat (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(s_in_ready), .op_a(op_a), .op_b(op_b),
        .approx_prod(approx_prod), .busy(s_busy), .done(s_done),
        .sample_count(s_sample_count), .err_count(s_err_count), .sum_ed(s_sum_ed),
        .max_ed(s_max_ed), .sum_sq_ed(s_sum_sq_ed)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int bits);
        longint mx = (longint'(1) << bits) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic push(input int a, input int b, input int p);
        qa.push_back(a); qb.push_back(b); qp.push_back(p);
    endtask

    task automatic rand_sample(output int a, output int b, output int p);
        int ex;
        a = $urandom_range(255);
        b = $urandom_range(255);
        ex = a * b;
        case ($urandom_range(3))
            0: p = ex;
            1: p = (ex + $urandom_range(15)) & 'h1FFFF;
            2: p = (ex - $urandom_range(15)) & 'h1FFFF;
            default: p = $urandom_range('h1FFFF);
        endcase
    endtask

    task automatic check_idle_stats(input string tag, input longint cnt, input longint err,
                                    input longint sum, input longint mx, input longint sq);
        longint sq_exp = 0, s_sq_exp = 0;
`ifdef MULT_ERR_SQ_EN
        sq_exp = sat(sq, AW);
        s_sq_exp = sat(sq, AWS);
`endif
        chk({tag, "_cnt"}, sample_count, cnt);
        chk({tag, "_err"}, err_count, err);
        chk({tag, "_sum"}, sum_ed, sat(sum, AW));
        chk({tag, "_max"}, max_ed, mx);
        chk({tag, "_sq"}, sum_sq_ed, sq_exp);
        chk({tag, "_s_cnt"}, s_sample_count, cnt);
        chk({tag, "_s_err"}, s_err_count, err);
        chk({tag, "_s_sum"}, s_sum_ed, sat(sum, AWS));
        chk({tag, "_s_max"}, s_max_ed, mx);
        chk({tag, "_s_sq"}, s_sum_sq_ed, s_sq_exp);
    endtask

    // One run: start, present samples each cycle with vpct% valid, wait for done, check stats.
    task automatic run(input string tag, input int n, input int vpct, input int max_cyc,
                       output int n_acc);
        longint m_err = 0, m_sum = 0, m_max = 0, m_sq = 0;
        int acc = 0, last_acc = -1, done_cyc = -1, a, b, p, ex, ed;
        int acc_hist[$];
        bit exp_rdy, v;

        @(negedge clk);
        start = 1'b1; num_samples = CW'(n); in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            exp_rdy = (acc < n);
            chk({tag, "_rdy"}, in_ready, exp_rdy);
            chk({tag, "_busy"}, busy, n != 0);
            chk({tag, "_lat"}, sample_count, (cyc >= 3) ? acc_hist[cyc-3] : 0);
            if (qa.size() > 0) begin a = qa[0]; b = qb[0]; p = qp[0]; end
            else rand_sample(a, b, p);
            v = ($urandom_range(99) < vpct);
            op_a = W'(a); op_b = W'(b); approx_prod = (2*W+1)'(p); in_valid = v;
            if (v && exp_rdy) begin
                if (qa.size() > 0) begin void'(qa.pop_front()); void'(qb.pop_front()); void'(qp.pop_front()); end
                ex = a * b;
                ed = (p > ex) ? p - ex : ex - p;
                m_err += (ed != 0);
                m_sum += ed;
                m_sq  += longint'(ed) * ed;
                if (ed > m_max) m_max = ed;
                acc++;
                last_acc = cyc;
            end
            acc_hist.push_back(acc);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk({tag, "_done_seen"}, done_cyc >= 0, 1);
        if (n == 0) chk({tag, "_done_lat"}, done_cyc, 0);
        else        chk({tag, "_done_lat"}, (done_cyc - last_acc >= 4) && (done_cyc - last_acc <= 5), 1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_busy_end"}, busy, 0);
        check_idle_stats(tag, acc, m_err, m_sum, m_max, m_sq);
        n_acc = acc;
    endtask

    initial begin
        int na;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rdy", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        check_idle_stats("rst", 0, 0, 0, 0, 0);
        rst = 1'b0;

        push(3, 5, 15); push(255, 255, 65025); push(0, 7, 0); push(16, 16, 256);
        run("exact", 4, 100, 40, na);
        chk("exact_cnt_k", sample_count, 4);
        chk("exact_sum_k", sum_ed, 0);

        push(10, 10, 96); push(20, 5, 104); push(7, 7, 49);
        run("errs", 3, 100, 40, na);
        chk("errs_err_k", err_count, 2);
        chk("errs_sum_k", sum_ed, 8);
        chk("errs_max_k", max_ed, 4);
`ifdef MULT_ERR_SQ_EN
        chk("errs_sq_k", sum_sq_ed, 32);
`endif

        run("hs", 5, 100, 40, na);
        chk("hs_xfers", na, 5);

        run("zero", 0, 100, 10, na);
        chk("zero_cnt_k", sample_count, 0);

        for (int i = 0; i < 20; i++) begin
            int a = $urandom_range(255), b = $urandom_range(255);
            push(a, b, a * b + 20);
        end
        run("satur", 20, 100, 60, na);
        chk("satur_s_sum_k", s_sum_ed, 255);
        chk("satur_s_max_k", s_max_ed, 20);
        chk("satur_s_err_k", s_err_count, 20);
        chk("satur_sum_k", sum_ed, 400);

        // Reset three samples into a ten-sample run.
        for (int i = 0; i < 3; i++) push(10, 10, 90 + i);
        @(negedge clk);
        start = 1'b1; num_samples = 10;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op_a = W'(qa[0]); op_b = W'(qb[0]); approx_prod = (2*W+1)'(qp[0]); in_valid = 1'b1;
            void'(qa.pop_front()); void'(qb.pop_front()); void'(qp.pop_front());
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("prerst_cnt", sample_count, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_rdy", in_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        check_idle_stats("midrst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        run("postrst", 6, 80, 80, na);

        for (int r = 0; r < 8; r++)
            run("rand", $urandom_range(1, 40), $urandom_range(30, 100), 400, na);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mult_error_accum.md
Name: mult_error_accum

Overview:
- Downstream stage of the dadda8/dadda16 approximate multipliers.
- Consumes operand pairs together with the approximate product `RES`/`prod` that the multiplier produced for them.
- Computes the exact product internally and accumulates error statistics over a programmed number of samples: error count, sum of error distance (ED), max ED.
- Used in the error-analysis harness that sweeps multiplier configurations.

Parameters:
- WIDTH, 8, operand width (8 or 16 supported).
- CNT_W, 32, width of the sample counters and `num_samples`.
- ACC_W, 48, width of the ED sum accumulator.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a run and clears all statistics.
- num_samples  in  CNT_W  samples per run; sampled when `start` is accepted.
- in_valid  in  1  `op_a`/`op_b`/`approx_prod` are valid.
- in_ready  out  1  block accepts a sample this cycle.
- op_a  in  WIDTH  multiplicand fed to the multiplier.
- op_b  in  WIDTH  multiplier operand.
- approx_prod  in  2*WIDTH+1  multiplier result, including the adder carry-out bit.
- busy  out  1  run in progress (RUN or DRAIN).
- done  out  1  one-cycle pulse when the run completes.
- sample_count  out  CNT_W  samples accumulated in this run.
- err_count  out  CNT_W  samples with ED != 0.
- sum_ed  out  ACC_W  saturating sum of ED.
- max_ed  out  2*WIDTH+1  maximum ED seen.
- sum_sq_ed  out  ACC_W  saturating sum of ED squared; present only with the optional feature.

Behaviour:
- Reset (async, rst=1): FSM=IDLE, pipeline valids cleared. `in_ready`, `busy`, `done`, `sample_count`, `err_count`, `sum_ed`, `max_ed`, `sum_sq_ed` all 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start`=1 latches `num_samples`, clears all statistics and the accepted counter.
  - Goes to RUN if `num_samples` != 0, otherwise to DONE.
- RUN:
  - `in_ready` = 1 while accepted < `num_samples`.
  - A transfer happens when `in_valid` & `in_ready`.
  - On the transfer that makes accepted == `num_samples`, go to DRAIN; `in_ready` is 0 from the next cycle.
- DRAIN: `in_ready` = 0; wait until both pipeline stages are empty, then go to DONE.
- DONE: `done` = 1 for exactly one cycle, then IDLE. Statistics hold until the next `start`.
- `busy` = 1 in RUN and DRAIN.
- `start` while not in IDLE is ignored.
- `in_valid` while `in_ready` = 0 is ignored; no data is captured.
- Pipeline (fixed, no stalls):
  - S1 registers `op_a`, `op_b`, `approx_prod` and the valid bit.
  - S2 registers exact = `op_a` * `op_b` (zero-extended to 2*WIDTH+1) and ED = |approx − exact| (2*WIDTH+1 bits, unsigned).
  - S3 updates the statistics on S2 valid.
  - A sample accepted at cycle t is reflected in the outputs at t+3.
- Statistics update per valid sample:
  - `sample_count` += 1.
  - `err_count` += (ED != 0).
  - `sum_ed` += ED, saturating at all-ones.
  - `max_ed` = max(`max_ed`, ED).
- `sample_count` and `err_count` never exceed `num_samples`, so they need no saturation.
- Back-to-back samples every cycle are supported.
- `start` in the same cycle as `done`: `done` is asserted in DONE, where `start` is ignored. `start` is accepted from IDLE the following cycle.
- `rst` mid-run: immediate return to IDLE with all outputs 0; samples in flight are discarded.

Optional Feature:
- Macro: MULT_ERR_SQ_EN.
- Defined:
  - S2 additionally registers ED*ED (2*(2*WIDTH+1) bits).
  - S3 adds it to `sum_sq_ed`, saturating at all-ones, using the same valid and clear rules as `sum_ed`.
  - Used for MSE.
  - Latency is unchanged.
- Not defined: the `sum_sq_ed` port still exists, is tied to 0, and no multiplier/adder for it is synthesised.

Test Plan:
- Reset: assert `rst` mid-RUN after 3 samples -> all outputs 0 and FSM in IDLE within the same cycle; next `start` runs cleanly.
- Exact stream, WIDTH=8, `num_samples`=4, pairs (3,5,15), (255,255,65025), (0,7,0), (16,16,256) -> `sample_count`=4, `err_count`=0, `sum_ed`=0, `max_ed`=0; `done` pulses once, 3 cycles after the last accept + DRAIN.
- Error stream, `num_samples`=3, (10,10,approx 96), (20,5,approx 104), (7,7,approx 49) -> `err_count`=2, `sum_ed`=8, `max_ed`=4; with MULT_ERR_SQ_EN, `sum_sq_ed`=32.
- Handshake: `in_valid` held high for 10 cycles with `num_samples`=5 -> exactly 5 transfers, `in_ready` low from cycle 6; samples presented while `in_ready`=0 do not change the counts.
- Zero samples: `start` with `num_samples`=0 -> `busy` never set, `done` pulses 1 cycle later, all statistics 0.
- Saturation: ACC_W=8, 20 samples each with ED=20 -> `sum_ed` holds at 255, `max_ed`=20, `err_count`=20.
